// File: rtl/sbox_lane_pipe_if.sv
// Valid/ready stream bundle for the multi-lane AES S-box pipeline.
interface sbox_lane_pipe_if #(
  parameter int LANES = 4,
  parameter int TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [8*LANES-1:0]   in_data;
  logic                 in_inv;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*LANES-1:0]   out_data;
  logic [TAG_W-1:0]     out_tag;
  logic [2:0]           occupancy;

  modport slave (
    input  in_valid, in_data, in_inv, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, occupancy
  );

  modport master (
    output in_valid, in_data, in_inv, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, occupancy
  );
endinterface

// File: rtl/sbox_lane_pipe.sv
// Multi-lane AES SubBytes/InvSubBytes engine: 6-stage composite-field
// GF(((2^2)^2)^2) datapath per lane, global stall, tag and mode sideband.

module sbox_lane #(
  parameter bit INV_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv_i,
  input  logic       ld_i,
  input  logic       inv_s0_i,
  input  logic       inv_s3_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o
);
  // GF(4): x^2+x+1.  GF(16): y^2+y+phi, phi=x.  GF(256): z^2+z+lambda.
  function automatic logic [1:0] gf4_mul(logic [1:0] a, logic [1:0] b);
    return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
            (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  function automatic logic [3:0] gf16_mul(logic [3:0] a, logic [3:0] b);
    logic [1:0] hh;
    logic [1:0] hh_phi;
    hh     = gf4_mul(a[3:2], b[3:2]);
    hh_phi = {hh[1] ^ hh[0], hh[1]};
    return {hh ^ gf4_mul(a[3:2], b[1:0]) ^ gf4_mul(a[1:0], b[3:2]),
            hh_phi ^ gf4_mul(a[1:0], b[1:0])};
  endfunction

  function automatic logic [3:0] gf16_inv(logic [3:0] a);
    logic [3:0] r;
    r = 4'h0;
    for (int b = 1; b < 16; b++)
      if (gf16_mul(a, 4'(b)) == 4'h1) r = 4'(b);
    return r;
  endfunction

  // Any lambda with no root of z^2+z+lambda in GF(16) makes the tower a field.
  function automatic logic [3:0] find_lambda();
    logic       ok;
    logic [3:0] r;
    r = 4'h0;
    for (int l = 15; l > 0; l--) begin
      ok = 1'b1;
      for (int y = 0; y < 16; y++)
        if ((gf16_mul(4'(y), 4'(y)) ^ 4'(y)) == 4'(l)) ok = 1'b0;
      if (ok) r = 4'(l);
    end
    return r;
  endfunction

  localparam logic [3:0] LAMBDA = find_lambda();

  function automatic logic [7:0] gf256_mul(logic [7:0] a, logic [7:0] b);
    logic [3:0] hh;
    hh = gf16_mul(a[7:4], b[7:4]);
    return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
            gf16_mul(hh, LAMBDA) ^ gf16_mul(a[3:0], b[3:0])};
  endfunction

  function automatic logic [7:0] mat_mul(logic [7:0][7:0] m, logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++)
      if (x[i]) r = r ^ m[i];
    return r;
  endfunction

  // Columns of the AES->tower map are powers of a root of the AES polynomial.
  function automatic logic [7:0][7:0] iso_cols();
    logic [8:0][7:0] p;
    logic [7:0][7:0] r;
    logic            found;
    r     = '0;
    found = 1'b0;
    for (int b = 2; b < 256; b++) begin
      p[0] = 8'h01;
      for (int i = 1; i < 9; i++) p[i] = gf256_mul(p[i-1], 8'(b));
      if (!found && (p[8] ^ p[4] ^ p[3] ^ p[1] ^ p[0]) == 8'h00) begin
        found = 1'b1;
        for (int i = 0; i < 8; i++) r[i] = p[i];
      end
    end
    return r;
  endfunction

  function automatic logic [7:0][7:0] inv_cols(logic [7:0][7:0] m);
    logic [7:0][7:0] r;
    r = '0;
    for (int j = 0; j < 8; j++)
      for (int a = 0; a < 256; a++)
        if (mat_mul(m, 8'(a)) == 8'(1 << j)) r[j] = 8'(a);
    return r;
  endfunction

  localparam logic [7:0][7:0] ISO     = iso_cols();
  localparam logic [7:0][7:0] ISO_INV = inv_cols(ISO);

  function automatic logic [7:0] aff_fwd(logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++)
      y[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8];
    return y ^ 8'h63;
  endfunction

  function automatic logic [7:0] aff_inv(logic [7:0] x);
    logic [7:0] t;
    logic [7:0] y;
    t = x ^ 8'h63;
    for (int i = 0; i < 8; i++)
      y[i] = t[(i+2)%8] ^ t[(i+5)%8] ^ t[(i+7)%8];
    return y;
  endfunction

  logic [7:0] s0_q, s0_d;
  logic [3:0] d1_q, d1_d, h1_q, l1_q;
  logic [3:0] dinv2_q, dinv2_d, h2_q, l2_q;
  logic [7:0] inv3_q, inv3_d;
  logic [7:0] o4_q, o4_d, o5_q;
  logic [7:0] unmap3;

  always_comb begin
    s0_d    = mat_mul(ISO, (INV_EN && inv_s0_i) ? aff_inv(din_i) : din_i);
    d1_d    = gf16_mul(gf16_mul(s0_q[7:4], s0_q[7:4]), LAMBDA)
            ^ gf16_mul(s0_q[7:4] ^ s0_q[3:0], s0_q[3:0]);
    dinv2_d = gf16_inv(d1_q);
    inv3_d  = {gf16_mul(h2_q, dinv2_q), gf16_mul(h2_q ^ l2_q, dinv2_q)};
    unmap3  = mat_mul(ISO_INV, inv3_q);
    o4_d    = inv_s3_i ? unmap3 : aff_fwd(unmap3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q    <= '0;
      d1_q    <= '0;
      h1_q    <= '0;
      l1_q    <= '0;
      dinv2_q <= '0;
      h2_q    <= '0;
      l2_q    <= '0;
      inv3_q  <= '0;
      o4_q    <= '0;
      o5_q    <= '0;
    end else begin
      if (ld_i) s0_q <= s0_d;
      if (adv_i) begin
        d1_q    <= d1_d;
        h1_q    <= s0_q[7:4];
        l1_q    <= s0_q[3:0];
        dinv2_q <= dinv2_d;
        h2_q    <= h1_q;
        l2_q    <= l1_q;
        inv3_q  <= inv3_d;
        o4_q    <= o4_d;
        o5_q    <= o4_q;
      end
    end
  end

  assign dout_o = o5_q;
endmodule

module sbox_lane_pipe #(
  parameter int LANES  = 4,
  parameter int TAG_W  = 4,
  parameter bit INV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  sbox_lane_pipe_if.slave  bus
);
  localparam int STAGES = 6;

  logic                         adv, ld, inv_in;
  logic [STAGES-1:0]            vld_pipe_q, vld_pipe_d;
  logic [STAGES-1:0][TAG_W-1:0] tag_q;
  logic [3:0]                   inv_q;
  logic [2:0]                   occ_q, occ_d;
  logic [LANES-1:0][7:0]        lane_out;

  assign adv          = !vld_pipe_q[STAGES-1] || bus.out_ready;
  assign ld           = adv && bus.in_valid;
  assign inv_in       = INV_EN ? bus.in_inv : 1'b0;
  assign bus.in_ready = adv || rst;

  always_comb begin
    vld_pipe_d = adv ? {vld_pipe_q[STAGES-2:0], bus.in_valid} : vld_pipe_q;
    occ_d      = '0;
    for (int i = 0; i < STAGES; i++) occ_d = occ_d + {2'b00, vld_pipe_d[i]};
  end

  // Only S0..S3 need the mode bit; S4 consumes it for the output transform.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      tag_q      <= '0;
      inv_q      <= '0;
      occ_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      occ_q      <= occ_d;
      if (ld) begin
        tag_q[0] <= bus.in_tag;
        inv_q[0] <= inv_in;
      end
      if (adv) begin
        for (int i = 1; i < STAGES; i++) tag_q[i] <= tag_q[i-1];
        inv_q[3:1] <= inv_q[2:0];
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sbox_lane #(.INV_EN(INV_EN)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .adv_i    (adv),
      .ld_i     (ld),
      .inv_s0_i (inv_in),
      .inv_s3_i (inv_q[3]),
      .din_i    (bus.in_data[8*k +: 8]),
      .dout_o   (lane_out[k])
    );
  end

  assign bus.out_valid = vld_pipe_q[STAGES-1];
  assign bus.out_data  = lane_out;
  assign bus.out_tag   = tag_q[STAGES-1];
  assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_sbox_lane_pipe.sv
// Scoreboard bench for sbox_lane_pipe: S-box tables are derived from
// GF(2^8)/0x11B arithmetic and the FIPS-197 affine rule.
module tb_sbox_lane_pipe;
  localparam int LANES = 4;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sbox_lane_pipe_if #(.LANES(LANES), .TAG_W(TAG_W)) a_if ();
  sbox_lane_pipe_if #(.LANES(LANES), .TAG_W(TAG_W)) b_if ();

  sbox_lane_pipe #(.LANES(LANES), .TAG_W(TAG_W), .INV_EN(1'b1)) dut (
    .clk (clk), .rst (rst), .bus (a_if));
  sbox_lane_pipe #(.LANES(LANES), .TAG_W(TAG_W), .INV_EN(1'b0)) dut_fwd (
    .clk (clk), .rst (rst), .bus (b_if));

  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    int          cyc;
  } exp_t;

  exp_t        expq[$];
  logic [7:0]  sb  [256];
  logic [7:0]  isb [256];
  int          nvec = 0, nerr = 0, cyc = 0, nret = 0, peak = 0;
  bit          lat_en = 1'b0, prev_stall = 1'b0;
  logic [31:0] held_d;
  logic [3:0]  held_t;

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] ginv(logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int b = 1; b < 256; b++)
      if (gmul(a, 8'(b)) == 8'h01) return 8'(b);
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] x, int n);
    logic [7:0] r;
    r = (x << n) | (x >> (8 - n));
    return r;
  endfunction

  function automatic logic [31:0] model(logic [31:0] d, logic inv);
    logic [31:0] r;
    for (int k = 0; k < LANES; k++)
      r[8*k +: 8] = inv ? isb[d[8*k +: 8]] : sb[d[8*k +: 8]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard the handshakes seen before the edge, then check occupancy.
  task automatic tick(output logic acc);
    logic ret;
    exp_t e;
    #1;
    acc = a_if.in_valid && a_if.in_ready && !rst;
    ret = a_if.out_valid && a_if.out_ready && !rst;
    if (!rst) begin
      if (prev_stall) begin
        chk("hold_data", a_if.out_data, held_d);
        chk("hold_tag", a_if.out_tag, held_t);
      end
      if (a_if.out_valid && !a_if.out_ready) chk("stall_in_ready", a_if.in_ready, 1'b0);
    end
    if (ret) begin
      if (expq.size() == 0) chk("spurious_out", a_if.out_valid, 1'b0);
      else begin
        e = expq.pop_front();
        chk("out_data", a_if.out_data, e.d);
        chk("out_tag", a_if.out_tag, e.t);
        if (lat_en) chk("latency", cyc - e.cyc, 6);
        nret++;
      end
    end
    prev_stall = a_if.out_valid && !a_if.out_ready && !rst;
    held_d     = a_if.out_data;
    held_t     = a_if.out_tag;
    if (acc) begin
      e.d   = model(a_if.in_data, a_if.in_inv);
      e.t   = a_if.in_tag;
      e.cyc = cyc;
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) expq.delete();
    chk("occupancy", a_if.occupancy, expq.size());
    if (int'(a_if.occupancy) > peak) peak = a_if.occupancy;
  endtask

  task automatic drain();
    logic a;
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 40 && expq.size() > 0; i++) tick(a);
    chk("drain_empty", expq.size(), 0);
  endtask

  initial begin
    logic        a;
    logic [4:0]  pat;
    int          cur, c, r0;
    logic [7:0]  bi;

    for (int x = 0; x < 256; x++) begin
      bi = ginv(8'(x));
      sb[x] = bi ^ rotl(bi, 1) ^ rotl(bi, 2) ^ rotl(bi, 3) ^ rotl(bi, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);

    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_inv = 1'b0; a_if.in_tag = '0;
    a_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_inv = 1'b0; b_if.in_tag = '0;
    b_if.out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    tick(a); tick(a);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", a_if.out_valid, 1'b0);
    chk("rst_out_data", a_if.out_data, 32'h0);
    chk("rst_out_tag", a_if.out_tag, 4'h0);
    chk("rst_occupancy", a_if.occupancy, 3'd0);
    chk("rst_in_ready", a_if.in_ready, 1'b1);

    // Single forward transaction, exact latency
    lat_en = 1'b1;
    a_if.in_valid = 1'b1; a_if.in_data = 32'h5301FF00; a_if.in_tag = 4'h5; a_if.in_inv = 1'b0;
    tick(a);
    a_if.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(a);
      chk("fwd_not_early", a_if.out_valid, 1'b0);
    end
    tick(a);
    chk("fwd_valid", a_if.out_valid, 1'b1);
    chk("fwd_data", a_if.out_data, 32'hED7C1663);
    chk("fwd_tag", a_if.out_tag, 4'h5);
    tick(a);
    chk("fwd_one_cycle", a_if.out_valid, 1'b0);

    // Single inverse transaction, plus forward-only build with inv requested
    a_if.in_valid = 1'b1; a_if.in_data = 32'hED7C1663; a_if.in_tag = 4'h6; a_if.in_inv = 1'b1;
    b_if.in_valid = 1'b1; b_if.in_data = 32'h5301FF00; b_if.in_tag = 4'h9; b_if.in_inv = 1'b1;
    tick(a);
    a_if.in_valid = 1'b0; b_if.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick(a);
    chk("inv_data", a_if.out_data, 32'h5301FF00);
    chk("inv_valid", a_if.out_valid, 1'b1);
    chk("fwdonly_valid", b_if.out_valid, 1'b1);
    chk("fwdonly_data", b_if.out_data, 32'hED7C1663);
    chk("fwdonly_tag", b_if.out_tag, 4'h9);
    drain();

    // Alternating fwd/inv sweep: every byte value on every lane
    r0 = nret;
    for (int j = 0; j < 512; j++) begin
      a_if.in_valid = 1'b1;
      a_if.in_inv   = j[0];
      a_if.in_tag   = 4'(j);
      for (int k = 0; k < LANES; k++) a_if.in_data[8*k +: 8] = 8'((j >> 1) + 64 * k);
      tick(a);
    end
    a_if.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick(a);
    chk("sweep_throughput", nret - r0, 512);

    // Bubbles keep their spacing
    pat = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      a_if.in_valid = pat[i];
      a_if.in_data  = $urandom;
      a_if.in_inv   = 1'($urandom);
      a_if.in_tag   = 4'(i);
      tick(a);
    end
    drain();

    // Backpressure: 10 tags with a 4-cycle downstream hold
    lat_en = 1'b0;
    peak = 0; cur = 0; c = 0;
    while (cur < 10 && c < 100) begin
      a_if.in_valid  = 1'b1;
      a_if.in_tag    = 4'(cur);
      a_if.in_data   = $urandom;
      a_if.in_inv    = 1'($urandom);
      a_if.out_ready = !(c >= 6 && c < 10);
      tick(a);
      if (a) cur++;
      c++;
    end
    drain();
    chk("bp_all_sent", cur, 10);
    chk("bp_peak_occ", peak, 6);

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      a_if.in_valid  = 1'($urandom);
      a_if.in_data   = $urandom;
      a_if.in_inv    = 1'($urandom);
      a_if.in_tag    = 4'($urandom);
      a_if.out_ready = ($urandom_range(0, 3) != 0);
      tick(a);
    end
    drain();

    // Reset with three transactions in flight
    for (int i = 0; i < 3; i++) begin
      a_if.in_valid = 1'b1;
      a_if.in_data  = $urandom;
      a_if.in_tag   = 4'(i);
      tick(a);
    end
    a_if.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_in_ready_hi", a_if.in_ready, 1'b1);
    tick(a);
    rst = 1'b0;
    chk("midrst_out_valid", a_if.out_valid, 1'b0);
    chk("midrst_occupancy", a_if.occupancy, 3'd0);
    for (int i = 0; i < 10; i++) tick(a);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/sbox_lane_pipe.md
Name: sbox_lane_pipe

Overview:
- Parametrised, multi-lane, pipelined AES byte-substitution engine.
- Supports forward S-box (SubBytes) and inverse S-box (InvSubBytes), selected per transaction.
- Adds valid/ready flow control, a sideband tag and pipeline stall.
- Sits between the AES round-state register and ShiftRows/MixColumns, for both the encrypt and decrypt datapaths.

Parameters:
LANES, 4, number of independent byte lanes substituted per transaction (1..16).
TAG_W, 4, width of the sideband tag carried alongside the data (>=1).
INV_EN, 1, 1 = inverse mode supported; 0 = in_inv ignored and forward always used.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input transaction valid.
in_ready  out  1  pipeline can accept input this cycle.
in_data  in  8*LANES  input bytes; lane k = bits [8k+7:8k].
in_inv  in  1  1 = inverse S-box for this transaction.
in_tag  in  TAG_W  sideband tag, returned unchanged.
out_valid  out  1  output transaction valid.
out_ready  in  1  downstream accepts output.
out_data  out  8*LANES  substituted bytes, same lane ordering.
out_tag  out  TAG_W  tag of the transaction.
occupancy  out  3  number of valid transactions in flight (0..6).

Behaviour:
- Reset (rst=1 at clk edge):
  - All 6 stage valid bits clear; data and tag registers clear to 0.
  - out_valid=0, out_data=0, out_tag=0, occupancy=0.
  - Reset mid-operation discards all in-flight transactions.
  - in_ready is combinational: it is 1 during reset cycles, but no transfer is accepted while rst=1.
- Datapath per lane, composite-field GF((2^4)^2) arithmetic, 6 register stages. Latency is exactly 6 cycles with no stalls.
  - S0: input transform, registered. Forward = isomorphic map. Inverse = inverse affine (XOR 0x63, then inverse affine matrix) followed by the isomorphic map.
  - S1: high^2*lambda XOR (high^low)*low.
  - S2: GF(2^4) inversion.
  - S3: two GF(2^4) multiplies give the high and low halves of the GF(2^8) inverse.
  - S4: output transform. Forward = inverse-iso map + affine + 0x63. Inverse = inverse-iso map only.
  - S5: output register, which drives out_*.
  - GF(2^8) inverse of 0x00 is 0x00.
- Mode: the inv bit travels down the pipeline with its data. Mixed forward/inverse transactions may be back-to-back. With INV_EN=0, inv is forced to 0 at S0.
- Flow control, global stall:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - A transfer occurs when in_valid && in_ready.
  - When advance=1, every stage shifts one step. S0 loads the input with valid = in_valid.
  - When advance=0, every stage holds: data, tag, inv and valid.
  - Bubbles are not compressed while stalled.
  - out_data/out_tag hold stable while out_valid && !out_ready.
  - Input is not registered when in_valid=0 (data don't-care, valid=0).
- Output: out_valid=1 and out_ready=1 in the same cycle completes the transaction. The next stage's content appears the following cycle. Full throughput is 1 transaction/cycle.
- occupancy: count of set stage valid bits, registered, updated every cycle. Accept-and-retire in the same cycle leaves it unchanged.
- Lanes are independent and identical. There is no cross-lane logic.

Test Plan:
- Reset, then a single forward transaction: in_data=0x53_01_FF_00, tag=0x5, out_ready=1 → exactly 6 cycles later out_data=0xED_7C_16_63, out_tag=0x5, out_valid high for 1 cycle.
- Inverse: in_inv=1, in_data=0xED_7C_16_63 → out_data=0x53_01_FF_00. Then back-to-back alternating fwd/inv for all 256 bytes × 4 lanes, compared against the AES tables, with one result per cycle.
- Backpressure: stream 10 transactions (tags 0..9) and hold out_ready=0 for 4 cycles mid-stream → in_ready=0 during the hold, out_data/out_tag stable, no loss or duplication, tags in order 0..9, occupancy peaks at 6.
- Bubbles: in_valid pattern 1,0,1,1,0 with out_ready=1 → outputs keep the same spacing 6 cycles later; occupancy tracks correctly.
- Reset mid-flight: 3 transactions in flight, assert rst for 1 cycle → out_valid=0 and occupancy=0 the next cycle, and none of the 3 is ever emitted.
- INV_EN=0 build: in_inv=1 with 0x00 → out 0x63 (forward).
